// File: rtl/sha3_pkg.sv
// Shared SHA3 constants, lane type and helpers for the lane-serial Keccak datapath.
package sha3_pkg;
    localparam int NUM_LANES   = 25;
    localparam int PLANE_LANES = 5;
    localparam int LANE_WIDTH  = 64;

    localparam logic [4:0] LAST_LANE = 5'd24;

    typedef logic [LANE_WIDTH-1:0] lane_t;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DCALC = 2'd1,
        ST_EMIT  = 2'd2
    } theta_state_t;

    // rot(v,1)[z] = v[z-1]: the top bit wraps into bit 0.
    function automatic lane_t rotl1(input lane_t v);
        return {v[LANE_WIDTH-2:0], v[LANE_WIDTH-1]};
    endfunction

    // Column index x = i mod 5, advanced alongside the lane counter.
    function automatic logic [2:0] col_next(input logic [2:0] c);
        return (c == 3'd4) ? 3'd0 : c + 3'd1;
    endfunction
endpackage

// File: rtl/theta_d_calc.sv
// Combinational theta D vector: D[x] = C[x-1] ^ rot(C[x+1], 1), indices mod 5.
module theta_d_calc
    import sha3_pkg::*;
#(
    parameter int LANE_W = 64
) (
    input  logic [PLANE_LANES-1:0][LANE_W-1:0] c,
    output logic [PLANE_LANES-1:0][LANE_W-1:0] d
);

    if (LANE_W == LANE_WIDTH) begin : g_pkg_rot
        always_comb begin
            d = '0;
            for (int x = 0; x < PLANE_LANES; x++) begin
                d[x] = c[(x + 4) % PLANE_LANES] ^ rotl1(c[(x + 1) % PLANE_LANES]);
            end
        end
    end else begin : g_narrow_rot
        always_comb begin
            d = '0;
            for (int x = 0; x < PLANE_LANES; x++) begin
                d[x] = c[(x + 4) % PLANE_LANES] ^
                       {c[(x + 1) % PLANE_LANES][LANE_W-2:0], c[(x + 1) % PLANE_LANES][LANE_W-1]};
            end
        end
    end

endmodule

// File: rtl/theta_lane_seq.sv
// Lane-serial Keccak theta: buffers 25 lanes while folding column parities, then
// streams A'[x,y] = A[x,y] ^ D[x] in the same lane order.
module theta_lane_seq
    import sha3_pkg::*;
#(
    parameter int LANE_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    // Handshakes: a lane moves on a port in any cycle where valid & ready are both
    // high at the rising edge; valid never depends on ready, data holds while stalled.

    theta_state_t                       state;
    logic [4:0]                         lane_cnt;
    logic [2:0]                         col;
    logic [PLANE_LANES-1:0][LANE_W-1:0] c_reg;
    logic [PLANE_LANES-1:0][LANE_W-1:0] d_reg;
    logic [PLANE_LANES-1:0][LANE_W-1:0] d_next;
    logic [LANE_W-1:0]                  lane_buf [NUM_LANES];

    theta_d_calc #(.LANE_W(LANE_W)) u_d_calc (
        .c (c_reg),
        .d (d_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_ACCUM;
            lane_cnt <= '0;
            col      <= '0;
            c_reg    <= '0;
            d_reg    <= '0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        c_reg[col] <= c_reg[col] ^ in_data;
                        if (lane_cnt == LAST_LANE) begin
                            state    <= ST_DCALC;
                            lane_cnt <= '0;
                            col      <= '0;
                        end else begin
                            lane_cnt <= lane_cnt + 5'd1;
                            col      <= col_next(col);
                        end
                    end
                end
                ST_DCALC: begin
                    d_reg <= d_next;
                    state <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (lane_cnt == LAST_LANE) begin
                            // Parities must start clean for the next state.
                            c_reg    <= '0;
                            state    <= ST_ACCUM;
                            lane_cnt <= '0;
                            col      <= '0;
                        end else begin
                            lane_cnt <= lane_cnt + 5'd1;
                            col      <= col_next(col);
                        end
                    end
                end
                default: begin
                    state    <= ST_ACCUM;
                    lane_cnt <= '0;
                    col      <= '0;
                end
            endcase
        end
    end

    // Storage only; every entry is written during ACCUM before EMIT reads it.
    always_ff @(posedge clk) begin
        if (state == ST_ACCUM && in_valid) begin
            lane_buf[lane_cnt] <= in_data;
        end
    end

    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_EMIT);
    assign out_last  = (state == ST_EMIT) && (lane_cnt == LAST_LANE);
    assign out_data  = (state == ST_EMIT) ? (lane_buf[lane_cnt] ^ d_reg[col]) : '0;
    assign busy      = !((state == ST_ACCUM) && (lane_cnt == 5'd0));

endmodule

// File: tb/tb_theta_lane_seq.sv
// Bench for theta_lane_seq: directed and randomly throttled states, expected lanes
// queued at issue time and checked by an independent output monitor.
module tb_theta_lane_seq;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;

    logic [W:0]   exp_q[$];
    logic [W-1:0] st    [25];
    logic [W-1:0] exp_l [25];

    bit in_rand  = 1'b0;
    bit rdy_rand = 1'b0;

    theta_lane_seq #(.LANE_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  in_ready,  1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"},  out_last,  0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_out_data"},  out_data,  0);
    endtask

    task automatic clear_state();
        for (int i = 0; i < 25; i++) begin
            st[i]    = '0;
            exp_l[i] = '0;
        end
    endtask

    // Reference theta over the whole state array.
    task automatic golden();
        logic [W-1:0] c [5];
        logic [W-1:0] d [5];
        for (int x = 0; x < 5; x++) begin
            c[x] = '0;
            for (int y = 0; y < 5; y++) c[x] = c[x] ^ st[x + 5 * y];
        end
        for (int x = 0; x < 5; x++) begin
            d[x] = c[(x + 4) % 5] ^ {c[(x + 1) % 5][W-2:0], c[(x + 1) % 5][W-1]};
        end
        for (int i = 0; i < 25; i++) exp_l[i] = st[i] ^ d[i % 5];
    endtask

    task automatic push_exp();
        for (int i = 0; i < 25; i++) exp_q.push_back({(i == 24), exp_l[i]});
    endtask

    // driver: offers st[0..n-1]; entered and left at posedge + 1
    task automatic send_lanes(input int n);
        for (int i = 0; i < n; i++) begin
            int cyc  = 0;
            bit done = 1'b0;
            while (!done) begin
                in_valid = in_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data  = st[i];
                @(negedge clk);
                if (in_valid && in_ready) done = 1'b1;
                @(posedge clk);
                #1;
                cyc++;
                if (!done && cyc >= 300) begin
                    chk("in_handshake_timeout", 0, 1);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_state(input string tag);
        push_exp();
        send_lanes(25);
        @(negedge clk);
        chk({tag, "_dcalc_in_ready"},  in_ready,  0);
        chk({tag, "_dcalc_out_valid"}, out_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, "_first_out_valid"}, out_valid, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 1000) begin
            @(posedge clk);
            cyc++;
        end
        if (exp_q.size() != 0) begin
            chk({tag, "_drain_timeout"}, W'(exp_q.size()), 0);
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor / scoreboard
    initial begin
        bit           prev_stall = 1'b0;
        bit           last_hs    = 1'b0;
        logic [W-1:0] prev_data  = '0;
        logic         prev_last  = 1'b0;
        int           out_idx    = 0;
        logic [W:0]   e;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_stall = 1'b0;
                last_hs    = 1'b0;
                out_idx    = 0;
            end else begin
                if (last_hs) begin
                    chk("in_ready_after_last", in_ready, 1);
                    chk("busy_after_last",     busy,     0);
                    last_hs = 1'b0;
                end
                if (prev_stall) begin
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_out_data",  out_data,  prev_data);
                    chk("stall_out_last",  out_last,  prev_last);
                end
                if (out_valid) chk("in_ready_during_emit", in_ready, 0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", out_data, 0);
                        chk("unexpected_output_valid", out_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("out_data[%0d]", out_idx), out_data, e[W-1:0]);
                        chk($sformatf("out_last[%0d]", out_idx), out_last, e[W]);
                        if (e[W]) last_hs = 1'b1;
                        out_idx = (out_idx == 24) ? 0 : out_idx + 1;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        clear_state();

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // all-zero state
        clear_state();
        send_state("zero");
        drain("zero");

        // single bit in lane 0
        clear_state();
        st[0] = 64'h1;
        exp_l[0] = 64'h1;
        for (int y = 0; y < 5; y++) begin
            exp_l[1 + 5 * y] = 64'h1;
            exp_l[4 + 5 * y] = 64'h2;
        end
        send_state("lane0");
        drain("lane0");

        // top bit in lane 1 wraps to bit 0 of column 0
        clear_state();
        st[1] = 64'h8000000000000000;
        exp_l[1] = 64'h8000000000000000;
        for (int y = 0; y < 5; y++) begin
            exp_l[2 + 5 * y] = 64'h8000000000000000;
            exp_l[0 + 5 * y] = 64'h1;
        end
        send_state("wrap");
        drain("wrap");

        // random states with random valid/ready throttling
        in_rand  = 1'b1;
        rdy_rand = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 25; i++) st[i] = {$urandom, $urandom};
            golden();
            send_state("rand");
            drain("rand");
        end
        in_rand  = 1'b0;
        rdy_rand = 1'b0;

        // reset after 12 lanes discards the partial state
        for (int i = 0; i < 25; i++) st[i] = {$urandom, $urandom};
        send_lanes(12);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_state();
        send_state("after_reset");
        drain("after_reset");

        // back-to-back: lane 0 = 1, then all zero
        clear_state();
        st[0] = 64'h1;
        exp_l[0] = 64'h1;
        for (int y = 0; y < 5; y++) begin
            exp_l[1 + 5 * y] = 64'h1;
            exp_l[4 + 5 * y] = 64'h2;
        end
        send_state("b2b_first");
        clear_state();
        send_state("b2b_second");
        drain("b2b");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
